// File: rtl/mips_pkg.sv
// Shared MIPS encoding definitions for the instruction encoder and decoder:
// operation select, opcode/func constants and the pure field-packing function.
package mips_pkg;

   typedef enum logic [2:0] {
      OP_ADDU  = 3'd0,
      OP_OR    = 3'd1,
      OP_ADDIU = 3'd2,
      OP_SW    = 3'd3,
      OP_LW    = 3'd4,
      OP_JAL   = 3'd5
   } op_sel_t;

   localparam logic [5:0] OPC_RTYPE = 6'b000000;
   localparam logic [5:0] OPC_ADDIU = 6'b001001;
   localparam logic [5:0] OPC_SW    = 6'b101011;
   localparam logic [5:0] OPC_LW    = 6'b100011;
   localparam logic [5:0] OPC_JAL   = 6'b000011;

   localparam logic [5:0] FUNC_ADDU = 6'b100001;
   localparam logic [5:0] FUNC_OR   = 6'b100101;

   typedef struct packed {
      logic        illegal;
      logic [31:0] word;
   } enc_t;

   // Packs the fields relevant to each format; unused fields are ignored.
   // Selects 6 and 7 have no instruction and come back flagged illegal.
   function automatic enc_t encode(input logic [2:0]  op,
                                   input logic [4:0]  rs,
                                   input logic [4:0]  rt,
                                   input logic [4:0]  rd,
                                   input logic [15:0] imm,
                                   input logic [25:0] target);
      enc_t r;
      r.illegal = 1'b0;
      r.word    = 32'd0;
      case (op)
         OP_ADDU:  r.word = {OPC_RTYPE, rs, rt, rd, 5'd0, FUNC_ADDU};
         OP_OR:    r.word = {OPC_RTYPE, rs, rt, rd, 5'd0, FUNC_OR};
         OP_ADDIU: r.word = {OPC_ADDIU, rs, rt, imm};
         OP_SW:    r.word = {OPC_SW, rs, rt, imm};
         OP_LW:    r.word = {OPC_LW, rs, rt, imm};
         OP_JAL:   r.word = {OPC_JAL, target};
         default:  r.illegal = 1'b1;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request and instruction-word streams of the instruction encoder.
// master drives requests and consumes words; slave is the encoder.
interface instr_encoder_if;

   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_op;
   logic [4:0]  in_rs;
   logic [4:0]  in_rt;
   logic [4:0]  in_rd;
   logic [15:0] in_imm;
   logic [25:0] in_target;

   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [31:0] out_addr;

   modport master (
      output in_valid, in_op, in_rs, in_rt, in_rd, in_imm, in_target, out_ready,
      input  in_ready, out_valid, out_data, out_addr
   );

   modport slave (
      input  in_valid, in_op, in_rs, in_rt, in_rd, in_imm, in_target, out_ready,
      output in_ready, out_valid, out_data, out_addr
   );

endinterface

// File: rtl/skid_fifo2.sv
// Two-entry FIFO. slot0 is always the head; a pop shifts slot1 forward and a
// push lands in the first free slot after that shift, so push+pop at one
// entry replaces the head in a single cycle.
module skid_fifo2 #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic [1:0]       count
);

   logic [WIDTH-1:0] slot0, slot1;
   logic [WIDTH-1:0] slot0_nxt, slot1_nxt;
   logic [1:0]       count_nxt;
   logic             do_pop, do_push;

   assign do_pop    = pop && (count != 2'd0);
   assign do_push   = push && (count != 2'd2);
   assign head_data = slot0;

   // Next state: apply the pop first, then write into the slot it leaves free.
   always_comb begin
      slot0_nxt = slot0;
      slot1_nxt = slot1;
      count_nxt = count;
      if (do_pop) begin
         slot0_nxt = slot1;
         count_nxt = count - 2'd1;
      end
      if (do_push) begin
         if (count_nxt == 2'd0) slot0_nxt = push_data;
         else                   slot1_nxt = push_data;
         count_nxt = count_nxt + 2'd1;
      end
   end

   // Storage and occupancy; clear empties the FIFO and zeroes the head word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot0 <= '0;
         slot1 <= '0;
         count <= 2'd0;
      end else if (clear) begin
         slot0 <= '0;
         slot1 <= '0;
         count <= 2'd0;
      end else begin
         slot0 <= slot0_nxt;
         slot1 <= slot1_nxt;
         count <= count_nxt;
      end
   end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: turns symbolic requests into MIPS words with
// sequential byte addresses for loading instruction memory. Illegal selects
// are consumed and counted but produce no word.
module instr_encoder
   import mips_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned DEPTH     = 256
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clear,
   instr_encoder_if.slave  bus,
   output logic            done,
   output logic            err_illegal,
   output logic [7:0]      illegal_cnt
);

   // 31 bits hold any DEPTH up to 2^30 inclusive.
   localparam logic [30:0] DEPTH_C = 31'(DEPTH);

   enc_t        enc;
   logic [1:0]  count;
   logic [30:0] issued, popped;
   logic        accept, push, pop;

   assign enc = encode(bus.in_op, bus.in_rs, bus.in_rt, bus.in_rd,
                       bus.in_imm, bus.in_target);

   // Ready depends on registered state only, so a pop into a full FIFO does
   // not reopen the input until the following cycle.
   assign bus.in_ready  = (count != 2'd2) && (issued < DEPTH_C);
   assign accept        = bus.in_valid && bus.in_ready;
   assign push          = accept && !enc.illegal;
   assign bus.out_valid = (count != 2'd0);
   assign pop           = bus.out_valid && bus.out_ready;

   skid_fifo2 #(.WIDTH(32)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .push      (push),
      .push_data (enc.word),
      .pop       (pop),
      .head_data (bus.out_data),
      .count     (count)
   );

   // Issue/pop counters, output address, completion and illegal-request tracking.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         issued       <= '0;
         popped       <= '0;
         bus.out_addr <= BASE_ADDR;
         done         <= 1'b0;
         err_illegal  <= 1'b0;
         illegal_cnt  <= 8'd0;
      end else if (clear) begin
         issued       <= '0;
         popped       <= '0;
         bus.out_addr <= BASE_ADDR;
         done         <= 1'b0;
         err_illegal  <= 1'b0;
         illegal_cnt  <= 8'd0;
      end else begin
         if (push) issued <= issued + 31'd1;
         if (pop) begin
            popped       <= popped + 31'd1;
            bus.out_addr <= bus.out_addr + 32'd4;
            if (popped + 31'd1 == DEPTH_C) done <= 1'b1;
         end
         if (accept && enc.illegal) begin
            err_illegal <= 1'b1;
            if (illegal_cnt != 8'hFF) illegal_cnt <= illegal_cnt + 8'd1;
         end
      end
   end

endmodule
